// File: rtl/alu_flags_8_bit_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 8-bit ALU stage:
//   - 4-bit opcode encodings (ALU_PASS_A .. ALU_NAND)
//   - flag bit positions within the {Z,C,N,O} flag register
//   - output-buffer state encoding
//   - flag_mask(): which flag bits an opcode is allowed to update
// Optional feature macro: ALU_OVF_EN (enables the O flag update).
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int WIDTH = 8;

    localparam logic [3:0] ALU_PASS_A = 4'h0;
    localparam logic [3:0] ALU_PASS_B = 4'h1;
    localparam logic [3:0] ALU_NOT_A  = 4'h2;
    localparam logic [3:0] ALU_NOT_B  = 4'h3;
    localparam logic [3:0] ALU_ADD    = 4'h4;
    localparam logic [3:0] ALU_ADC    = 4'h5;
    localparam logic [3:0] ALU_SUB    = 4'h6;
    localparam logic [3:0] ALU_AND    = 4'h7;
    localparam logic [3:0] ALU_OR     = 4'h8;
    localparam logic [3:0] ALU_XOR    = 4'h9;
    localparam logic [3:0] ALU_LSL    = 4'hA;
    localparam logic [3:0] ALU_LSR    = 4'hB;
    localparam logic [3:0] ALU_ASR    = 4'hC;
    localparam logic [3:0] ALU_ROL    = 4'hD;
    localparam logic [3:0] ALU_ROR    = 4'hE;
    localparam logic [3:0] ALU_NAND   = 4'hF;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_t;

    // Z and N follow every op; C only for arithmetic and shift/rotate ops;
    // O only for the add/subtract family, and only when overflow is built.
    function automatic logic [3:0] flag_mask(input logic [3:0] op);
        logic [3:0] m;
        m         = 4'b0000;
        m[FLAG_Z] = 1'b1;
        m[FLAG_N] = 1'b1;
        case (op)
            ALU_ADD, ALU_ADC, ALU_SUB: begin
                m[FLAG_C] = 1'b1;
`ifdef ALU_OVF_EN
                m[FLAG_O] = 1'b1;
`endif
            end
            ALU_LSL, ALU_LSR, ALU_ASR, ALU_ROL, ALU_ROR: begin
                m[FLAG_C] = 1'b1;
            end
            default: ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_flags_8_bit_if.sv
// ---------------------------------------------------------------------------
// alu_flags_8_bit_if
// Request/response bundle between the register file side (master) and the
// ALU stage (slave).
//   master drives : A, B, FunSel, Start, FlagWE, Ack
//   slave drives  : Ready, Valid, OutALU, Flags, dbg_state
// Handshake: a request is accepted on a rising edge where Start && Ready;
// a result is held on OutALU while Valid=1 until the edge where Ack=1.
// Ready = EMPTY || Ack, so an acknowledging cycle may also accept a new op.
// dbg_state exposes the output-buffer state for observation.
// ---------------------------------------------------------------------------
interface alu_flags_8_bit_if;
    import alu_pkg::*;

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       FunSel;
    logic             Start;
    logic             FlagWE;
    logic             Ack;
    logic             Ready;
    logic             Valid;
    logic [WIDTH-1:0] OutALU;
    logic [3:0]       Flags;
    buf_state_t       dbg_state;

    modport master (
        output A, B, FunSel, Start, FlagWE, Ack,
        input  Ready, Valid, OutALU, Flags, dbg_state
    );

    modport slave (
        input  A, B, FunSel, Start, FlagWE, Ack,
        output Ready, Valid, OutALU, Flags, dbg_state
    );

endinterface

// File: rtl/alu_core_8_bit.sv
// ---------------------------------------------------------------------------
// alu_core_8_bit
// Purely combinational datapath: computes result, carry-out and signed
// overflow for one opcode.
//   i_a, i_b    : operands
//   i_fun_sel   : opcode (alu_pkg encodings)
//   i_cin       : carry flag value used by ADC and the rotates
//   o_result    : operation result
//   o_cout      : carry-out (0 for ops that do not produce one)
//   o_ovf       : signed overflow of the adder; constant 0 unless
//                 ALU_OVF_EN is defined
// ---------------------------------------------------------------------------
module alu_core_8_bit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_fun_sel,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] w_b_eff;
    logic             w_add_cin;
    logic [WIDTH:0]   w_sum;

    // One shared adder: subtract is A + ~B + 1, so carry=1 means no borrow.
    always_comb begin
        w_b_eff   = (i_fun_sel == ALU_SUB) ? ~i_b : i_b;
        w_add_cin = 1'b0;
        case (i_fun_sel)
            ALU_ADC: w_add_cin = i_cin;
            ALU_SUB: w_add_cin = 1'b1;
            default: w_add_cin = 1'b0;
        endcase
        w_sum = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_add_cin};
    end

    always_comb begin
        o_result = '0;
        o_cout   = 1'b0;
        case (i_fun_sel)
            ALU_PASS_A: o_result = i_a;
            ALU_PASS_B: o_result = i_b;
            ALU_NOT_A:  o_result = ~i_a;
            ALU_NOT_B:  o_result = ~i_b;
            ALU_ADD,
            ALU_ADC,
            ALU_SUB: begin
                o_result = w_sum[MSB:0];
                o_cout   = w_sum[WIDTH];
            end
            ALU_AND:    o_result = i_a & i_b;
            ALU_OR:     o_result = i_a | i_b;
            ALU_XOR:    o_result = i_a ^ i_b;
            ALU_LSL: begin
                o_result = {i_a[MSB-1:0], 1'b0};
                o_cout   = i_a[MSB];
            end
            ALU_LSR: begin
                o_result = {1'b0, i_a[MSB:1]};
                o_cout   = i_a[0];
            end
            ALU_ASR: begin
                o_result = {i_a[MSB], i_a[MSB:1]};
                o_cout   = i_a[0];
            end
            ALU_ROL: begin
                o_result = {i_a[MSB-1:0], i_cin};
                o_cout   = i_a[MSB];
            end
            ALU_ROR: begin
                o_result = {i_cin, i_a[MSB:1]};
                o_cout   = i_a[0];
            end
            ALU_NAND:   o_result = ~(i_a & i_b);
            default:    o_result = '0;
        endcase
    end

`ifdef ALU_OVF_EN
    // Using the effective B operand makes one rule cover both cases:
    // for subtract, ~B flips B's sign, so "signs equal" becomes
    // "A and B signs differ", and the result is compared against A.
    assign o_ovf = (i_a[MSB] == w_b_eff[MSB]) && (w_sum[MSB] != i_a[MSB]);
`else
    assign o_ovf = 1'b0;
`endif

endmodule

// File: rtl/alu_flags_8_bit.sv
// ---------------------------------------------------------------------------
// alu_flags_8_bit
// ALU stage with a single-entry output buffer and a {Z,C,N,O} flag register.
//   Clock : rising-edge clock
//   Reset : asynchronous, active-high; clears OutALU, Valid, Flags, state
//   bus   : alu_flags_8_bit_if.slave (A, B, FunSel, Start, FlagWE, Ack in;
//           Ready, Valid, OutALU, Flags, dbg_state out)
// Optional feature macro: ALU_OVF_EN. When undefined, Flags[0] stays 0.
// ---------------------------------------------------------------------------
module alu_flags_8_bit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    alu_flags_8_bit_if.slave     bus
);

    buf_state_t       r_state;
    buf_state_t       w_next_state;
    logic [WIDTH-1:0] r_out;
    logic [3:0]       r_flags;

    logic             w_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_result;
    logic             w_cout;
    logic             w_ovf;
    logic [3:0]       w_new_flags;
    logic [3:0]       w_mask;

    alu_core_8_bit #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a       (bus.A),
        .i_b       (bus.B),
        .i_fun_sel (bus.FunSel),
        .i_cin     (r_flags[FLAG_C]),
        .o_result  (w_result),
        .o_cout    (w_cout),
        .o_ovf     (w_ovf)
    );

    // A FULL buffer can accept in the same cycle it is acknowledged,
    // which gives one result per cycle when Ack is held high.
    assign w_ready  = (r_state == ST_EMPTY) || bus.Ack;
    assign w_accept = bus.Start && w_ready;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_next_state = ST_FULL;
            ST_FULL:  if (bus.Ack && !bus.Start) w_next_state = ST_EMPTY;
            default:  w_next_state = ST_EMPTY;
        endcase
    end

    always_comb begin
        w_new_flags         = 4'b0000;
        w_new_flags[FLAG_Z] = (w_result == '0);
        w_new_flags[FLAG_C] = w_cout;
        w_new_flags[FLAG_N] = w_result[WIDTH-1];
        w_new_flags[FLAG_O] = w_ovf;
        w_mask              = flag_mask(bus.FunSel);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_EMPTY;
            r_out   <= '0;
            r_flags <= 4'b0000;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_out <= w_result;
                if (bus.FlagWE) begin
                    r_flags <= (r_flags & ~w_mask) | (w_new_flags & w_mask);
                end
            end
        end
    end

    assign bus.Ready     = w_ready;
    assign bus.Valid     = (r_state == ST_FULL);
    assign bus.OutALU    = r_out;
    assign bus.Flags     = r_flags;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_alu_flags_8_bit.sv
// ---------------------------------------------------------------------------
// tb_alu_flags_8_bit
// Directed test of alu_flags_8_bit: reset, handshake, arithmetic/logic ops
// and flag behaviour. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_flags_8_bit;
    import alu_pkg::*;

    logic Clock;
    logic Reset;
    int   checks;
    int   errors;
    logic ov;

    alu_flags_8_bit_if bus ();

    alu_flags_8_bit #(
        .WIDTH (8)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic op(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                      input logic fwe);
        bus.Start  = 1'b1;
        bus.FunSel = f;
        bus.A      = a;
        bus.B      = b;
        bus.FlagWE = fwe;
    endtask

    initial begin
        checks = 0;
        errors = 0;
`ifdef ALU_OVF_EN
        ov = 1'b1;
`else
        ov = 1'b0;
`endif
        Reset      = 1'b1;
        bus.A      = 8'h00;
        bus.B      = 8'h00;
        bus.FunSel = 4'h0;
        bus.Start  = 1'b0;
        bus.FlagWE = 1'b0;
        bus.Ack    = 1'b0;
        step();
        step();
        Reset = 1'b0;

        // Reset arriving while a request is pending discards it.
        op(ALU_ADD, 8'h12, 8'h34, 1'b1);
        #3 Reset = 1'b1;
        step();
        check("rst_valid", {7'd0, bus.Valid}, 8'h00);
        check("rst_out", bus.OutALU, 8'h00);
        check("rst_flags", {4'd0, bus.Flags}, 8'h00);
        check("rst_ready", {7'd0, bus.Ready}, 8'h01);
        bus.Start = 1'b0;
        Reset     = 1'b0;
        step();
        check("post_rst_valid", {7'd0, bus.Valid}, 8'h00);
        check("post_rst_out", bus.OutALU, 8'h00);
        check("post_rst_flags", {4'd0, bus.Flags}, 8'h00);
        check("post_rst_state", {7'd0, bus.dbg_state}, {7'd0, ST_EMPTY});

        // Add with carry out, held without Ack.
        op(ALU_ADD, 8'hFF, 8'h01, 1'b1);
        step();
        check("add_out", bus.OutALU, 8'h00);
        check("add_valid", {7'd0, bus.Valid}, 8'h01);
        check("add_flags", {4'd0, bus.Flags}, 8'h0C);
        check("add_ready", {7'd0, bus.Ready}, 8'h00);

        // Backpressure: Start while not ready is ignored.
        op(ALU_PASS_A, 8'h55, 8'h00, 1'b1);
        step();
        check("bp_out", bus.OutALU, 8'h00);
        check("bp_valid", {7'd0, bus.Valid}, 8'h01);
        check("bp_flags", {4'd0, bus.Flags}, 8'h0C);
        bus.Start = 1'b0;
        bus.Ack   = 1'b1;
        #1;
        check("ack_ready", {7'd0, bus.Ready}, 8'h01);
        step();
        check("ack_empty_valid", {7'd0, bus.Valid}, 8'h00);
        check("ack_empty_state", {7'd0, bus.dbg_state}, {7'd0, ST_EMPTY});

        // Subtract with borrow clears C; Ack stays high from here.
        op(ALU_SUB, 8'h00, 8'h01, 1'b1);
        step();
        check("sub_borrow_out", bus.OutALU, 8'hFF);
        check("sub_borrow_flags", {4'd0, bus.Flags}, 8'h02);

        // Carry chain back-to-back.
        op(ALU_ADD, 8'hFF, 8'h01, 1'b1);
        step();
        check("chain1_out", bus.OutALU, 8'h00);
        check("chain1_flags", {4'd0, bus.Flags}, 8'h0C);
        op(ALU_ADC, 8'h00, 8'h00, 1'b1);
        step();
        check("chain2_out", bus.OutALU, 8'h01);
        check("chain2_flags", {4'd0, bus.Flags}, 8'h00);
        check("chain2_valid", {7'd0, bus.Valid}, 8'h01);

        // Signed overflow on add.
        op(ALU_ADD, 8'h7F, 8'h01, 1'b1);
        step();
        check("ovf_out", bus.OutALU, 8'h80);
        check("ovf_flags", {4'd0, bus.Flags}, {4'd0, 3'b001, ov});

        // LSL sets C; O untouched.
        op(ALU_LSL, 8'h80, 8'h00, 1'b1);
        step();
        check("lsl_out", bus.OutALU, 8'h00);
        check("lsl_flags", {4'd0, bus.Flags}, {4'd0, 3'b110, ov});

        // Logic op keeps C.
        op(ALU_AND, 8'hF0, 8'h0F, 1'b1);
        step();
        check("and_out", bus.OutALU, 8'h00);
        check("and_flags", {4'd0, bus.Flags}, {4'd0, 3'b110, ov});

        // FlagWE=0 leaves flags alone.
        op(ALU_ADD, 8'h01, 8'h01, 1'b0);
        step();
        check("nowe_out", bus.OutALU, 8'h02);
        check("nowe_flags", {4'd0, bus.Flags}, {4'd0, 3'b110, ov});

        // Rotate right through carry (C=1 in).
        op(ALU_ROR, 8'h02, 8'h00, 1'b1);
        step();
        check("ror_out", bus.OutALU, 8'h81);
        check("ror_flags", {4'd0, bus.Flags}, {4'd0, 3'b001, ov});

        // Arithmetic shift right keeps MSB.
        op(ALU_ASR, 8'h81, 8'h00, 1'b1);
        step();
        check("asr_out", bus.OutALU, 8'hC0);
        check("asr_flags", {4'd0, bus.Flags}, {4'd0, 3'b011, ov});

        // ADC with C=1 in, no overflow clears O.
        op(ALU_ADC, 8'h10, 8'h20, 1'b1);
        step();
        check("adc_out", bus.OutALU, 8'h31);
        check("adc_flags", {4'd0, bus.Flags}, 8'h00);

        // Subtract without borrow, signed overflow.
        op(ALU_SUB, 8'h80, 8'h01, 1'b1);
        step();
        check("sub_out", bus.OutALU, 8'h7F);
        check("sub_flags", {4'd0, bus.Flags}, {4'd0, 3'b010, ov});

        // NAND and final drain.
        op(ALU_NAND, 8'hF0, 8'h3C, 1'b1);
        step();
        check("nand_out", bus.OutALU, 8'hCF);
        check("nand_flags", {4'd0, bus.Flags}, {4'd0, 3'b011, ov});
        bus.Start = 1'b0;
        step();
        check("drain_valid", {7'd0, bus.Valid}, 8'h00);
        step();
        check("ack_empty_ignored", {7'd0, bus.Valid}, 8'h00);

        // Asynchronous reset takes effect without a clock edge.
        #2 Reset = 1'b1;
        #1;
        check("async_rst_out", bus.OutALU, 8'h00);
        check("async_rst_flags", {4'd0, bus.Flags}, 8'h00);
        Reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
